paddle_btn_cond: RTL and testbench
==================================

PADDLE_BTN_COND -- requirements
Module: paddle_btn_cond

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000; stable-input cycles required before the debounced state flips (10 ms at 25 MHz).
REQ-002 Parameter CNT_W, default 18; debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-003 Parameter BTN_ACTIVE_LOW, default 0; 1 = raw pins read 0 when pressed.
REQ-004 clk  input  1  single system clock; all logic is on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert and active-low.
REQ-006 btn_up_raw  input  1  asynchronous mechanical up button.
REQ-007 btn_down_raw  input  1  asynchronous mechanical down button.
REQ-008 frame_tick  input  1  one-cycle pulse at pixel (0,0), from the top-level frame_start.
REQ-009 up_en  output  1  registered level; paddle-up request feeding object control and game start.
REQ-010 down_en  output  1  registered level; paddle-down request.
REQ-011 start_pulse  output  1  one-cycle pulse on each new press of either button.

Function
REQ-012 Each raw input shall pass a 2-FF synchronizer and then be inverted when BTN_ACTIVE_LOW=1; the result is "synced pressed".
REQ-013 Each button shall have its own 4-state FSM:
- RELEASED: synced=1 -> ARM_PRESS, counter cleared.
- ARM_PRESS: synced=0 -> RELEASED; counter==DEBOUNCE_CYCLES-1 with synced=1 -> HELD.
- HELD: synced=0 -> ARM_RELEASE, counter cleared.
- ARM_RELEASE: synced=1 -> HELD; counter==DEBOUNCE_CYCLES-1 with synced=0 -> RELEASED.
REQ-014 The counter shall increment only in ARM_* states, clear on every state change, and never wrap.
REQ-015 The debounced level shall be 1 in HELD and ARM_RELEASE, and 0 otherwise.
REQ-016 up_en shall be registered as up_db & ~down_db; down_en shall be registered as down_db & ~up_db.
REQ-017 When both buttons are debounced-pressed, up_en=down_en=0.
REQ-018 start_pulse shall be 1 for exactly one cycle, on the cycle after (up_db|down_db) rises.
REQ-019 start_pulse shall not repeat while either button remains held, including when the second button is pressed.
REQ-020 Latency: an input that stays stable from cycle 0 shall change up_en/down_en at cycle DEBOUNCE_CYCLES+3 (2 sync + DEBOUNCE_CYCLES FSM + 1 output register).
REQ-021 Any bounce shorter than DEBOUNCE_CYCLES shall produce no output change and no start_pulse.

Reset
REQ-022 While rst_n=0: FSMs in RELEASED, counters=0, synchronizer flops=0 (post-polarity inactive), up_en=down_en=start_pulse=0.
REQ-023 Reset asserted mid-debounce shall discard the partial count; after release, a full DEBOUNCE_CYCLES of stable input is needed again.
REQ-024 A button held through reset deassertion shall be treated as a new press, including start_pulse.

Configuration
REQ-025 Macro PADDLE_BTN_FRAME_LOCK_EN, when defined: the up_en/down_en output registers load only on cycles where frame_tick=1 and otherwise hold; start_pulse is unaffected.
REQ-026 Without PADDLE_BTN_FRAME_LOCK_EN: the output registers load every cycle per REQ-016, and frame_tick is ignored.

Structure
REQ-027 Package pong_pkg shall hold the btn_state_t enum (RELEASED, ARM_PRESS, HELD, ARM_RELEASE) and the default DEBOUNCE_CYCLES/CNT_W constants.
REQ-028 Sub-module btn_debounce (synchronizer + FSM + counter, output db level) shall be instantiated twice; conflict masking, start_pulse and the frame-lock logic live in paddle_btn_cond.

Verification (DEBOUNCE_CYCLES=8, BTN_ACTIVE_LOW=0)
REQ-029 btn_up_raw 0->1 held at cycle 0 -> up_en=1 first at cycle 11; start_pulse=1 at cycle 11 only; down_en stays 0.
REQ-030 btn_up_raw toggling every 3 cycles for 40 cycles, then 0 -> up_en and start_pulse never assert.
REQ-031 Up held and stable, then down pressed -> once down debounces, both outputs 0 and no second start_pulse; up released -> down_en=1 DEBOUNCE_CYCLES+3 cycles later.
REQ-032 rst_n low for 1 cycle at count 5 of an up press, input held -> up_en=1 eleven cycles after rst_n rises, with start_pulse.
REQ-033 With PADDLE_BTN_FRAME_LOCK_EN, up debounced at cycle 11 and frame_tick at cycle 30 -> up_en rises at cycle 31; start_pulse still at cycle 11.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and default constants for the pong button-conditioning path.
package pong_pkg;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        ARM_PRESS   = 2'd1,
        HELD        = 2'd2,
        ARM_RELEASE = 2'd3
    } btn_state_t;

    // 10 ms at 25 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;
    localparam int DEFAULT_CNT_W           = 18;

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-FF synchronizer, polarity fix, 4-state debounce FSM with
// a saturating stability counter. db is high in HELD and ARM_RELEASE.
module btn_debounce
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W,
    parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic             sync1, sync2;
    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Polarity is applied ahead of the first flop so reset value 0 means "not pressed".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw ^ BTN_ACTIVE_LOW;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RELEASED: begin
                if (sync2) begin
                    state_d = ARM_PRESS;
                    cnt_d   = '0;
                end
            end
            ARM_PRESS: begin
                if (!sync2) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q != CMAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!sync2) begin
                    state_d = ARM_RELEASE;
                    cnt_d   = '0;
                end
            end
            ARM_RELEASE: begin
                if (sync2) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q != CMAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    assign db = (state_q == HELD) || (state_q == ARM_RELEASE);

endmodule

// File: rtl/paddle_btn_cond.sv
// Paddle button conditioning: two debouncers, conflict masking, start pulse.
// Optional macro PADDLE_BTN_FRAME_LOCK_EN: up_en/down_en update only on frame_tick.
module paddle_btn_cond
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W,
    parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    input  logic frame_tick,
    output logic up_en,
    output logic down_en,
    output logic start_pulse
);

    logic up_db, down_db;
    logic any_db, any_db_q;
    logic load;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W),
        .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_up (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (btn_up_raw),
        .db   (up_db)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W),
        .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_down (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (btn_down_raw),
        .db   (down_db)
    );

`ifdef PADDLE_BTN_FRAME_LOCK_EN
    assign load = frame_tick;
`else
    logic unused_frame_tick;
    assign unused_frame_tick = frame_tick;
    assign load = 1'b1;
`endif

    assign any_db = up_db | down_db;

    // Both pressed cancels out; start fires only on the first button of a hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_en       <= 1'b0;
            down_en     <= 1'b0;
            any_db_q    <= 1'b0;
            start_pulse <= 1'b0;
        end else begin
            if (load) begin
                up_en   <= up_db & ~down_db;
                down_en <= down_db & ~up_db;
            end
            any_db_q    <= any_db;
            start_pulse <= any_db & ~any_db_q;
        end
    end

endmodule

// File: tb/tb_paddle_btn_cond.sv
// Directed bench for paddle_btn_cond with DEBOUNCE_CYCLES=8, active-high buttons.
module tb_paddle_btn_cond;

    localparam int DC = 8;

    logic clk = 1'b0;
    logic rst_n, btn_up_raw, btn_down_raw, frame_tick;
    logic up_en, down_en, start_pulse;

    int checks = 0;
    int errors = 0;

    paddle_btn_cond #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (4),
        .BTN_ACTIVE_LOW (1'b0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_up_raw  (btn_up_raw),
        .btn_down_raw(btn_down_raw),
        .frame_tick  (frame_tick),
        .up_en       (up_en),
        .down_en     (down_en),
        .start_pulse (start_pulse)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs change and outputs are read here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; btn_up_raw = 1'b0; btn_down_raw = 1'b0; frame_tick = 1'b1;
        tick(); tick();
        checks++; if (up_en !== 1'b0) begin errors++; $display("FAIL reset_up_en got %b exp 0", up_en); end
        checks++; if (down_en !== 1'b0) begin errors++; $display("FAIL reset_down_en got %b exp 0", down_en); end
        checks++; if (start_pulse !== 1'b0) begin errors++; $display("FAIL reset_start got %b exp 0", start_pulse); end
        rst_n = 1'b1;
        tick();
    endtask

    // Press up from idle: up_en rises at edge 11, start pulses there only.
    task automatic test_press_latency();
        btn_up_raw = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            tick();
            checks++;
            if (up_en !== (k >= DC + 3)) begin errors++; $display("FAIL press_up_en k=%0d got %b exp %b", k, up_en, k >= DC + 3); end
            checks++;
            if (start_pulse !== (k == DC + 3)) begin errors++; $display("FAIL press_start k=%0d got %b exp %b", k, start_pulse, k == DC + 3); end
            checks++;
            if (down_en !== 1'b0) begin errors++; $display("FAIL press_down_en k=%0d got %b exp 0", k, down_en); end
        end
    endtask

    // Up held; press down -> both masked; release up -> down_en after DC+3.
    task automatic test_conflict();
        btn_down_raw = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            tick();
            checks++;
            if (up_en !== (k < DC + 3)) begin errors++; $display("FAIL conflict_up_en k=%0d got %b exp %b", k, up_en, k < DC + 3); end
            checks++;
            if (down_en !== 1'b0) begin errors++; $display("FAIL conflict_down_en k=%0d got %b exp 0", k, down_en); end
            checks++;
            if (start_pulse !== 1'b0) begin errors++; $display("FAIL conflict_start k=%0d got %b exp 0", k, start_pulse); end
        end
        btn_up_raw = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            tick();
            checks++;
            if (down_en !== (k >= DC + 3)) begin errors++; $display("FAIL handoff_down_en k=%0d got %b exp %b", k, down_en, k >= DC + 3); end
            checks++;
            if (up_en !== 1'b0) begin errors++; $display("FAIL handoff_up_en k=%0d got %b exp 0", k, up_en); end
            checks++;
            if (start_pulse !== 1'b0) begin errors++; $display("FAIL handoff_start k=%0d got %b exp 0", k, start_pulse); end
        end
        btn_down_raw = 1'b0;
        for (int k = 0; k <= 20; k++) tick();
        checks++;
        if (down_en !== 1'b0) begin errors++; $display("FAIL release_down_en got %b exp 0", down_en); end
    endtask

    // Bounce toggling every 3 cycles never debounces.
    task automatic test_bounce();
        for (int k = 0; k < 60; k++) begin
            btn_up_raw = (k < 40) ? (((k / 3) % 2) == 0) : 1'b0;
            tick();
            checks++;
            if (up_en !== 1'b0) begin errors++; $display("FAIL bounce_up_en k=%0d got %b exp 0", k, up_en); end
            checks++;
            if (start_pulse !== 1'b0) begin errors++; $display("FAIL bounce_start k=%0d got %b exp 0", k, start_pulse); end
        end
    endtask

    // Reset at count 5 of an up press; held input is a fresh full press afterwards.
    task automatic test_reset_mid();
        btn_up_raw = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (up_en !== 1'b0) begin errors++; $display("FAIL midrst_up_en got %b exp 0", up_en); end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            tick();
            checks++;
            if (up_en !== (k >= DC + 3)) begin errors++; $display("FAIL midrst_up_en k=%0d got %b exp %b", k, up_en, k >= DC + 3); end
            checks++;
            if (start_pulse !== (k == DC + 3)) begin errors++; $display("FAIL midrst_start k=%0d got %b exp %b", k, start_pulse, k == DC + 3); end
        end
        btn_up_raw = 1'b0;
        for (int k = 0; k <= 16; k++) tick();
        checks++;
        if (up_en !== 1'b0) begin errors++; $display("FAIL midrst_release got %b exp 0", up_en); end
    endtask

    // frame_tick only after edge 30: locked build delays up_en, default ignores it.
    task automatic test_frame_tick();
        frame_tick = 1'b0;
        btn_up_raw = 1'b1;
        for (int k = 0; k <= 36; k++) begin
            tick();
            frame_tick = (k == 30);
            checks++;
`ifdef PADDLE_BTN_FRAME_LOCK_EN
            if (up_en !== (k >= 31)) begin errors++; $display("FAIL frame_up_en k=%0d got %b exp %b", k, up_en, k >= 31); end
`else
            if (up_en !== (k >= DC + 3)) begin errors++; $display("FAIL frame_up_en k=%0d got %b exp %b", k, up_en, k >= DC + 3); end
`endif
            checks++;
            if (start_pulse !== (k == DC + 3)) begin errors++; $display("FAIL frame_start k=%0d got %b exp %b", k, start_pulse, k == DC + 3); end
        end
        frame_tick = 1'b1;
        btn_up_raw = 1'b0;
        for (int k = 0; k <= 16; k++) tick();
        checks++;
        if (up_en !== 1'b0) begin errors++; $display("FAIL frame_release got %b exp 0", up_en); end
    endtask

    initial begin
        test_reset();
        test_press_latency();
        test_conflict();
        test_bounce();
        test_reset_mid();
        test_frame_tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
